pwm_peripheral: RTL and testbench

- Downstream consumer of the SPI register file.
- Takes the five configuration registers (output enables, PWM enables, duty cycle) and drives 16 output pins.
- Each pin is one of: forced low, static high, or a shared 8-bit PWM waveform.
- One prescaler and one 8-bit period counter are shared by all 16 channels.

---
 rtl/pwm_peripheral.sv | 83 ++++++++
 tb/tb_pwm_peripheral.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_peripheral.sv
// 16-channel PWM / static-drive output stage fed by the SPI register file.
// Optional macro PWM_SHADOW_EN: duty is latched at period boundaries instead of tracked live.
module pwm_peripheral #(
  parameter int PRESCALE = 13
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  en_reg_out_7_0,
  input  logic [7:0]  en_reg_out_15_8,
  input  logic [7:0]  en_reg_pwm_7_0,
  input  logic [7:0]  en_reg_pwm_15_8,
  input  logic [7:0]  pwm_duty_cycle,
  output logic [15:0] out,
  output logic        period_start
);

  logic [7:0]  prescaler;
  logic [7:0]  pwm_cnt;
  logic [7:0]  duty_active;
  logic [7:0]  duty_cmp;
  logic        tick;
  logic        wrap;
  logic        pwm_level;
  logic [15:0] en_out;
  logic [15:0] en_pwm;
  logic [15:0] pin_p0;

  assign tick = (prescaler == 8'(PRESCALE - 1));
  assign wrap = tick && (pwm_cnt == 8'hFF);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prescaler    <= '0;
      pwm_cnt      <= '0;
      period_start <= 1'b0;
    end else begin
      prescaler    <= tick ? 8'd0 : prescaler + 8'd1;
      if (tick)
        pwm_cnt <= pwm_cnt + 8'd1;
      period_start <= wrap;
    end
  end

`ifdef PWM_SHADOW_EN
  logic load_first;

  // The first post-reset cycle compares against the live input so period 0 is complete.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      duty_active <= '0;
      load_first  <= 1'b1;
    end else begin
      load_first <= 1'b0;
      if (wrap || load_first)
        duty_active <= pwm_duty_cycle;
    end
  end

  assign duty_cmp = load_first ? pwm_duty_cycle : duty_active;
`else
  assign duty_active = pwm_duty_cycle;
  assign duty_cmp    = duty_active;
`endif

  assign pwm_level = (duty_cmp == 8'hFF) || (pwm_cnt < duty_cmp);
  assign en_out    = {en_reg_out_15_8, en_reg_out_7_0};
  assign en_pwm    = {en_reg_pwm_15_8, en_reg_pwm_7_0};

  always_comb begin
    pin_p0 = '0;
    for (int i = 0; i < 16; i++)
      pin_p0[i] = en_out[i] & (en_pwm[i] ? pwm_level : 1'b1);
  end

  // stage p0 -> registered pins
  always_ff @(posedge clk) begin
    if (!rst_n)
      out <= '0;
    else
      out <= pin_p0;
  end

endmodule

// File: tb/tb_pwm_peripheral.sv
// Randomized self-checking bench for pwm_peripheral, two prescale settings side by side.
module tb_pwm_peripheral;
  localparam int P_A = 1;
  localparam int P_B = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  en_out_lo, en_out_hi, en_pwm_lo, en_pwm_hi, duty;
  logic [15:0] out_a, out_b;
  logic        ps_a, ps_b;

  int errors = 0;
  int checks = 0;
  int t = 0;
  logic [7:0] shadow_a, shadow_b;

  always #5 clk = ~clk;

  pwm_peripheral #(.PRESCALE(P_A)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .en_reg_out_7_0(en_out_lo), .en_reg_out_15_8(en_out_hi),
    .en_reg_pwm_7_0(en_pwm_lo), .en_reg_pwm_15_8(en_pwm_hi),
    .pwm_duty_cycle(duty), .out(out_a), .period_start(ps_a)
  );

  pwm_peripheral #(.PRESCALE(P_B)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .en_reg_out_7_0(en_out_lo), .en_reg_out_15_8(en_out_hi),
    .en_reg_pwm_7_0(en_pwm_lo), .en_reg_pwm_15_8(en_pwm_hi),
    .pwm_duty_cycle(duty), .out(out_b), .period_start(ps_b)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0d)", tag, obs, exp, t);
    end
  endtask

  // Pin value for a given duty and period position, straight from the channel rules.
  function automatic logic [15:0] pins(input logic [7:0] d, input int cnt);
    logic [15:0] eo, ep, r;
    logic lvl;
    eo  = {en_out_hi, en_out_lo};
    ep  = {en_pwm_hi, en_pwm_lo};
    lvl = (d == 8'hFF) || (cnt < int'(d));
    for (int i = 0; i < 16; i++)
      r[i] = eo[i] ? (ep[i] ? lvl : 1'b1) : 1'b0;
    return r;
  endfunction

  // One clock: predict, advance, compare. t counts cycles since the last reset edge.
  task automatic step();
    logic [15:0] ea, eb;
    logic pa, pb;
    logic [7:0] da, db;
    ea = '0; eb = '0; pa = 1'b0; pb = 1'b0;
    if (rst_n) begin
`ifdef PWM_SHADOW_EN
      if (t == 0) begin
        shadow_a = duty;
        shadow_b = duty;
      end
      da = shadow_a;
      db = shadow_b;
`else
      da = duty;
      db = duty;
`endif
      ea = pins(da, (t / P_A) % 256);
      eb = pins(db, (t / P_B) % 256);
      pa = (t % (256 * P_A)) == (256 * P_A - 1);
      pb = (t % (256 * P_B)) == (256 * P_B - 1);
`ifdef PWM_SHADOW_EN
      if (pa) shadow_a = duty;
      if (pb) shadow_b = duty;
`endif
    end
    @(posedge clk);
    #1;
    check_val("out_a", {16'h0, out_a}, {16'h0, ea});
    check_val("ps_a", {31'h0, ps_a}, {31'h0, pa});
    check_val("out_b", {16'h0, out_b}, {16'h0, eb});
    check_val("ps_b", {31'h0, ps_b}, {31'h0, pb});
    t = rst_n ? t + 1 : 0;
  endtask

  task automatic reset_align(input logic [7:0] d);
    rst_n = 1'b0;
    duty  = d;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic count_to_ps(input string tag);
    int n;
    n = 0;
    while (n < 300) begin
      step();
      n++;
      if (ps_a) break;
    end
    check_val(tag, n, 256);
  endtask

  initial begin
    int hi, hi2, fall, exp_fall, exp_hi1, uniform, others_one;
    int sweep_exp[5];
    logic [7:0] sweep_duty[5];
    logic [31:0] r;

    sweep_duty = '{8'h00, 8'h01, 8'h80, 8'hFE, 8'hFF};
    sweep_exp  = '{0, 1, 128, 254, 256};
    shadow_a = '0;
    shadow_b = '0;

    // Reset and idle
    rst_n = 1'b0;
    en_out_lo = 8'h00; en_out_hi = 8'h00; en_pwm_lo = 8'h00; en_pwm_hi = 8'h00;
    duty = 8'h80;
    repeat (3) step();
    check_val("reset_out", {16'h0, out_a}, 32'h0);
    check_val("reset_ps", {31'h0, ps_a}, 32'h0);
    rst_n = 1'b1;
    count_to_ps("first_ps");

    // Static drive
    en_out_lo = 8'hA5; en_out_hi = 8'h0F;
    step();
    check_val("static_out", {16'h0, out_a}, 32'h0FA5);
    repeat (5) step();
    check_val("static_hold", {16'h0, out_b}, 32'h0FA5);

    // Duty sweep, all channels in PWM mode
    en_out_lo = 8'hFF; en_out_hi = 8'hFF; en_pwm_lo = 8'hFF; en_pwm_hi = 8'hFF;
    for (int k = 0; k < 5; k++) begin
      reset_align(sweep_duty[k]);
      hi = 0;
      uniform = 1;
      repeat (256) begin
        step();
        if (out_a[0]) hi++;
        if (out_a != 16'h0000 && out_a != 16'hFFFF) uniform = 0;
      end
      check_val($sformatf("sweep_hi_%0h", sweep_duty[k]), hi, sweep_exp[k]);
      check_val($sformatf("sweep_uniform_%0h", sweep_duty[k]), uniform, 1);
    end

    // Mixed modes
    en_pwm_lo = 8'hF0; en_pwm_hi = 8'h00;
    reset_align(8'h40);
    hi = 0;
    others_one = 1;
    repeat (256) begin
      step();
      if (out_a[4]) hi++;
      if ((out_a | 16'h00F0) != 16'hFFFF) others_one = 0;
      if (out_a[7:4] != 4'h0 && out_a[7:4] != 4'hF) others_one = 0;
    end
    check_val("mixed_hi", hi, 64);
    check_val("mixed_static", others_one, 1);

    // Duty change mid-period
    en_pwm_lo = 8'hFF; en_pwm_hi = 8'hFF;
    reset_align(8'h80);
    hi = 0;
    fall = 0;
    for (int k = 1; k <= 256; k++) begin
      if (k == 17) duty = 8'h20;
      step();
      if (out_a[0]) hi++;
      else if (fall == 0) fall = k;
    end
    hi2 = 0;
    repeat (256) begin
      step();
      if (out_a[0]) hi2++;
    end
`ifdef PWM_SHADOW_EN
    exp_hi1  = 128;
    exp_fall = 129;
`else
    exp_hi1  = 32;
    exp_fall = 33;
`endif
    check_val("shadow_hi1", hi, exp_hi1);
    check_val("shadow_hi2", hi2, 32);
    check_val("shadow_fall", fall, exp_fall);

    // Reset mid-period
    reset_align(8'h80);
    repeat (8'h77) step();
    rst_n = 1'b0;
    step();
    check_val("midrst_out", {16'h0, out_a}, 32'h0);
    rst_n = 1'b1;
    count_to_ps("midrst_period");

    // Random traffic against the model
    for (int k = 0; k < 4000; k++) begin
      r = $urandom;
      if (r[3:0] == 4'h0) begin
        en_out_lo = 8'($urandom); en_out_hi = 8'($urandom);
        en_pwm_lo = 8'($urandom); en_pwm_hi = 8'($urandom);
      end
      if (r[6:4] == 3'h0) begin
        case (r[9:8])
          2'd0: duty = 8'h00;
          2'd1: duty = 8'hFF;
          default: duty = 8'($urandom);
        endcase
      end
      rst_n = ($urandom_range(0, 499) != 0);
      step();
    end
    rst_n = 1'b1;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
